// File: rtl/rv16_pkg.sv
// rv16 shared package: execute-stage widths and multiply-unit state encoding.
// Imported by the M-extension datapath blocks.
package rv16_pkg;

    localparam int DATA_W = 16;

    localparam int MUL_CNT_W = $clog2(DATA_W);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        NEG  = 2'd2
    } mul_state_t;

endpackage

// File: rtl/rv16_mul_unit.sv
// rv16 sequential radix-2 shift-add multiplier.
// Full 2*DATA product, fixed DATA+1 cycle latency, start/busy/done handshake.
module rv16_mul_unit
    import rv16_pkg::*;
#(
    parameter int DATA = DATA_W
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            mul_signed,
    input  logic [DATA-1:0] rs1_mul_in,
    input  logic [DATA-1:0] rs2_mul_in,
    output logic            busy,
    output logic            done,
    output logic [DATA-1:0] rd_mul_lo,
    output logic [DATA-1:0] rd_mul_hi
);

    localparam logic [MUL_CNT_W-1:0] CNT_LAST = MUL_CNT_W'(DATA - 1);

    mul_state_t           state;
    logic [MUL_CNT_W-1:0] count;
    logic [DATA-1:0]      mcand;
    logic [DATA-1:0]      mlier;
    logic [DATA-1:0]      acc;
    logic                 neg;

    logic [DATA-1:0]      rs1_abs;
    logic [DATA-1:0]      rs2_abs;
    logic                 neg_in;
    logic [DATA:0]        sum;
    logic [2*DATA-1:0]    prod;
    logic [2*DATA-1:0]    prod_fin;

    // Operand magnitudes and sign, plus one add step with carry and final fix-up
    always_comb begin
        rs1_abs  = rs1_mul_in;
        rs2_abs  = rs2_mul_in;
        neg_in   = 1'b0;
        if (mul_signed) begin
            rs1_abs = rs1_mul_in[DATA-1] ? -rs1_mul_in : rs1_mul_in;
            rs2_abs = rs2_mul_in[DATA-1] ? -rs2_mul_in : rs2_mul_in;
            neg_in  = rs1_mul_in[DATA-1] ^ rs2_mul_in[DATA-1];
        end
        sum      = {1'b0, acc} + (mlier[0] ? {1'b0, mcand} : '0);
        prod     = {acc, mlier};
        prod_fin = neg ? -prod : prod;
    end

    assign busy = (state != IDLE);

    // Control FSM and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            count     <= '0;
            mcand     <= '0;
            mlier     <= '0;
            acc       <= '0;
            neg       <= 1'b0;
            done      <= 1'b0;
            rd_mul_lo <= '0;
            rd_mul_hi <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        mcand <= rs1_abs;
                        mlier <= rs2_abs;
                        neg   <= neg_in;
                        acc   <= '0;
                        count <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    acc   <= sum[DATA:1];
                    mlier <= {sum[0], mlier[DATA-1:1]};
                    count <= count + 1'b1;
                    if (count == CNT_LAST) begin
                        state <= NEG;
                    end
                end
                NEG: begin
                    rd_mul_lo <= prod_fin[DATA-1:0];
                    rd_mul_hi <= prod_fin[2*DATA-1:DATA];
                    done      <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rv16_mul_unit.sv
// Scoreboard bench for rv16_mul_unit.
// Directed vectors; a monitor checks every done pulse against the queue.
module tb_rv16_mul_unit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        mul_signed;
    logic [15:0] rs1_mul_in;
    logic [15:0] rs2_mul_in;
    logic        busy;
    logic        done;
    logic [15:0] rd_mul_lo;
    logic [15:0] rd_mul_hi;

    typedef struct {
        logic [15:0] lo;
        logic [15:0] hi;
        int          cyc;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    rv16_mul_unit #(.DATA(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .mul_signed (mul_signed),
        .rs1_mul_in (rs1_mul_in),
        .rs2_mul_in (rs2_mul_in),
        .busy       (busy),
        .done       (done),
        .rd_mul_lo  (rd_mul_lo),
        .rd_mul_hi  (rd_mul_hi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every done pulse must match the oldest expected result
    always @(negedge clk) begin
        if (rst_n && done) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_done: got lo=%h hi=%h cyc=%0d, need no done",
                         rd_mul_lo, rd_mul_hi, cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (rd_mul_lo !== e.lo || rd_mul_hi !== e.hi ||
                    cyc != e.cyc || busy !== 1'b0) begin
                    bad++;
                    $display("FAIL %s: got hi=%h lo=%h cyc=%0d busy=%b, need hi=%h lo=%h cyc=%0d busy=0",
                             e.name, rd_mul_hi, rd_mul_lo, cyc, busy,
                             e.hi, e.lo, e.cyc);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] need);
        total++;
        if (got !== need) begin
            bad++;
            $display("FAIL %s: got %h need %h", nm, got, need);
        end
    endtask

    // Issue one op from idle; accepting edge is the next posedge
    task automatic issue(input string nm, input logic sg, input logic [15:0] a,
                         input logic [15:0] b, input logic [31:0] p);
        exp_t e;
        mul_signed = sg;
        rs1_mul_in = a;
        rs2_mul_in = b;
        start      = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        e.lo   = p[15:0];
        e.hi   = p[31:16];
        e.cyc  = cyc + 17;
        e.name = nm;
        exp_q.push_back(e);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            @(posedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL timeout: got %0d pending results, need 0", exp_q.size());
            exp_q.delete();
        end
        #1;
    endtask

    task automatic run(input string nm, input logic sg, input logic [15:0] a,
                       input logic [15:0] b, input logic [31:0] p);
        issue(nm, sg, a, b, p);
        @(negedge clk);
        chk({nm, "_busy"}, {31'd0, busy}, 32'd1);
        drain();
    endtask

    initial begin
        rst_n      = 1'b0;
        start      = 1'b0;
        mul_signed = 1'b0;
        rs1_mul_in = '0;
        rs2_mul_in = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_out", {rd_mul_hi, rd_mul_lo}, 32'h0);
        chk("reset_ctl", {30'd0, busy, done}, 32'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run("u_3x5",       1'b0, 16'h0003, 16'h0005, 32'h0000_000F);
        run("u_ffxff",     1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE_0001);
        run("s_m1x2",      1'b1, 16'hFFFF, 16'h0002, 32'hFFFF_FFFE);
        run("s_min_min",   1'b1, 16'h8000, 16'h8000, 32'h4000_0000);
        run("s_min_x1",    1'b1, 16'h8000, 16'h0001, 32'hFFFF_8000);
        run("s_5xm3",      1'b1, 16'h0005, 16'hFFFD, 32'hFFFF_FFF1);
        chk("hold_result", {rd_mul_hi, rd_mul_lo}, 32'hFFFF_FFF1);

        // start while busy is ignored
        issue("ignore_first", 1'b0, 16'h0010, 16'h0020, 32'h0000_0200);
        repeat (4) @(posedge clk);
        #1;
        mul_signed = 1'b1;
        rs1_mul_in = 16'hFFFF;
        rs2_mul_in = 16'hFFFF;
        start      = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        drain();
        repeat (25) @(posedge clk);
        #1;

        // reset mid-operation
        issue("aborted", 1'b0, 16'h0102, 16'h0304, 32'h0);
        exp_q.delete();
        repeat (8) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_out", {rd_mul_hi, rd_mul_lo}, 32'h0);
        chk("abort_ctl", {30'd0, busy, done}, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("abort_idle", {31'd0, busy}, 32'd0);
        run("after_rst",   1'b0, 16'h00FF, 16'h0101, 32'h0000_FFFF);

        // start held through the done cycle: back-to-back with no bubble
        issue("b2b_first", 1'b0, 16'h0007, 16'h0006, 32'h0000_002A);
        start      = 1'b1;
        rs1_mul_in = 16'h1234;
        rs2_mul_in = 16'h0000;
        begin
            exp_t e;
            e.lo   = 16'h0000;
            e.hi   = 16'h0000;
            e.cyc  = cyc + 18 + 17;
            e.name = "b2b_second";
            exp_q.push_back(e);
        end
        repeat (18) @(posedge clk);
        #1;
        start = 1'b0;
        drain();
        repeat (25) @(posedge clk);
        #1;
        chk("end_idle", {31'd0, busy}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
